// File: rtl/mdu_seq_pkg.sv
// Shared encodings and helpers for the multi-cycle multiply/divide unit.
`timescale 1ns/1ps
package mdu_seq_pkg;

   localparam int MDU_OP_W = 2;

   typedef enum logic [MDU_OP_W-1:0] {
      MDU_OP_MULT  = 2'b00,
      MDU_OP_MULTU = 2'b01,
      MDU_OP_DIV   = 2'b10,
      MDU_OP_DIVU  = 2'b11
   } mdu_op_e;

   function automatic logic op_is_div(input mdu_op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input mdu_op_e op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_abs.sv
// Parameterised two's-complement conditional negate: magnitude extraction and sign fix-up.
`timescale 1ns/1ps
module mdu_abs #(
   parameter int W = 32
) (
   input  logic [W-1:0] data_i,
   input  logic         neg_i,
   output logic [W-1:0] data_o
);

   assign data_o = neg_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO: radix-2 shift-add / restoring
// shift-subtract on operand magnitudes, then a one-cycle sign fix-up.
`timescale 1ns/1ps
module mdu_seq
   import mdu_seq_pkg::*;
#(
   parameter int DP_WIDTH  = 32,
   parameter int CNT_WIDTH = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [MDU_OP_W-1:0] op,
   input  logic [DP_WIDTH-1:0] a,
   input  logic [DP_WIDTH-1:0] b,
   input  logic                hi_we,
   input  logic                lo_we,
   input  logic [DP_WIDTH-1:0] wdata,
   output logic                busy,
   output logic                done,
   output logic                div_by_zero,
   output logic [DP_WIDTH-1:0] hi,
   output logic [DP_WIDTH-1:0] lo
);

   localparam int W = DP_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_e;

   state_e               state_q, state_d;
   mdu_op_e              op_q, op_d;
   logic                 sa_q, sa_d, sb_q, sb_d;
   logic                 dbz_q, dbz_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [W-1:0]         acc_hi_q, acc_hi_d;   // P_hi while multiplying, remainder while dividing
   logic [W-1:0]         acc_lo_q, acc_lo_d;   // P_lo while multiplying, quotient while dividing
   logic [W-1:0]         mag_b_q, mag_b_d;
   logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;

   mdu_op_e      op_in;
   logic         in_signed, accept;
   logic [W-1:0] mag_a, mag_b;
   logic [W-1:0] mul_add;
   logic [W:0]   mul_sum;
   logic [W:0]   rem_sh;
   logic         rem_ge;
   logic [W-1:0] rem_sub;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0] quo_fix, rem_fix;

   assign op_in     = mdu_op_e'(op);
   assign in_signed = op_is_signed(op_in);
   assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);

   mdu_abs #(.W(W)) u_abs_a (.data_i(a), .neg_i(in_signed & a[W-1]), .data_o(mag_a));
   mdu_abs #(.W(W)) u_abs_b (.data_i(b), .neg_i(in_signed & b[W-1]), .data_o(mag_b));

   assign mul_add = acc_lo_q[0] ? mag_b_q : '0;
   assign mul_sum = {1'b0, acc_hi_q} + {1'b0, mul_add};

   // The shifted partial remainder needs W+1 bits; the difference always fits back in W.
   assign rem_sh  = {acc_hi_q, acc_lo_q[W-1]};
   assign rem_ge  = rem_sh >= {1'b0, mag_b_q};
   assign rem_sub = rem_sh[W-1:0] - mag_b_q;

   mdu_abs #(.W(2*W)) u_fix_prod (
      .data_i({acc_hi_q, acc_lo_q}),
      .neg_i ((op_q == MDU_OP_MULT) & (sa_q ^ sb_q)),
      .data_o(prod_fix)
   );
   mdu_abs #(.W(W)) u_fix_quo (
      .data_i(acc_lo_q), .neg_i((op_q == MDU_OP_DIV) & (sa_q ^ sb_q)), .data_o(quo_fix)
   );
   mdu_abs #(.W(W)) u_fix_rem (
      .data_i(acc_hi_q), .neg_i((op_q == MDU_OP_DIV) & sa_q), .data_o(rem_fix)
   );

   always_comb begin
      // NOTE: every next-state variable takes its held value first so no path infers a latch.
      state_d  = state_q;
      op_d     = op_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      dbz_d    = dbz_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      mag_b_d  = mag_b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               op_d     = op_in;
               sa_d     = a[W-1];
               sb_d     = b[W-1];
               mag_b_d  = mag_b;
               dbz_d    = 1'b0;
               cnt_d    = '0;
               acc_hi_d = '0;
               acc_lo_d = mag_a;
               if (op_is_div(op_in) && b == '0) begin
                  dbz_d   = 1'b1;
                  hi_d    = a;
                  lo_d    = '1;
                  state_d = S_DONE;
               end else begin
                  state_d = op_is_div(op_in) ? S_DIV : S_MUL;
               end
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end
         S_MUL: begin
            acc_hi_d = mul_sum[W:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
            cnt_d    = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == '1) state_d = S_FIXUP;
         end
         S_DIV: begin
            acc_hi_d = rem_ge ? rem_sub : rem_sh[W-1:0];
            acc_lo_d = {acc_lo_q[W-2:0], rem_ge};
            cnt_d    = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == '1) state_d = S_FIXUP;
         end
         S_FIXUP: begin
            if (op_is_div(op_q)) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         op_q     <= MDU_OP_MULT;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         dbz_q    <= 1'b0;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         mag_b_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples the pre-edge values.
         state_q  <= state_d;
         op_q     <= op_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         dbz_q    <= dbz_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         mag_b_q  <= mag_b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIXUP);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed table-driven bench for mdu_seq plus hand-written multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_mdu_seq;
   import mdu_seq_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  a, b, wdata;
   logic          hi_we, lo_we;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mdu_seq #(.DP_WIDTH(W), .CNT_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           lat;
      logic         dbz;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issues one op and waits (bounded) for done; lat stays 0 if done never comes.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output logic busy_ok, output logic busy_at_done);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      lat = 0; busy_ok = 1'b1; busy_at_done = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = k;
            busy_at_done = busy;
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
   endtask

   task automatic wait_done(input int k0, output int lat);
      lat = 0;
      for (int k = k0; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int   lat;
      logic busy_ok, busy_at_done, no_done;

      rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      wdata = '0; hi_we = 1'b0; lo_we = 1'b0;

      vecs[0]  = '{MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, 1'b0};
      vecs[1]  = '{MDU_OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 1'b0};
      vecs[2]  = '{MDU_OP_MULT,  32'd7,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'hFFFF_FFC1, 34, 1'b0};
      vecs[3]  = '{MDU_OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34, 1'b0};
      vecs[4]  = '{MDU_OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0};
      vecs[5]  = '{MDU_OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34, 1'b0};
      vecs[6]  = '{MDU_OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34, 1'b0};
      vecs[7]  = '{MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34, 1'b0};
      vecs[8]  = '{MDU_OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1,  1'b1};
      vecs[9]  = '{MDU_OP_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1,  1'b1};
      vecs[10] = '{MDU_OP_MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         34, 1'b0};

      repeat (2) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_dbz",  64'(div_by_zero), 64'd0);
      check("reset_hi",   64'(hi), 64'd0);
      check("reset_lo",   64'(lo), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // MTHI + MTLO together, then MTLO alone
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      check("mt_both_hi", 64'(hi), 64'h1234_5678);
      check("mt_both_lo", 64'(lo), 64'h1234_5678);
      lo_we = 1'b1; wdata = 32'hCAFE_0001;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo_lo", 64'(lo), 64'hCAFE_0001);
      check("mtlo_hi", 64'(hi), 64'h1234_5678);

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_ok, busy_at_done);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
         check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
         check($sformatf("v%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].dbz));
         check($sformatf("v%0d_busy_at_done", i), 64'(busy_at_done), 64'd0);
         if (vecs[i].lat > 1) check($sformatf("v%0d_busy_window", i), 64'(busy_ok), 64'd1);
      end

      // Results hold after the done pulse
      @(negedge clk);
      check("hold_done", 64'(done), 64'd0);
      check("hold_hi", 64'(hi), 64'd0);
      check("hold_lo", 64'(lo), 64'd6);

      // start with MTHI/MTLO in the same cycle: writes dropped; MTHI while busy dropped
      @(negedge clk);
      start = 1'b1; op = MDU_OP_MULTU; a = 32'd7; b = 32'd9;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      check("collide_busy", 64'(busy), 64'd1);
      check("collide_hi_old", 64'(hi), 64'd0);
      check("collide_lo_old", 64'(lo), 64'd6);
      hi_we = 1'b1; wdata = 32'h5555_5555;
      @(negedge clk);
      hi_we = 1'b0;
      check("busy_mthi_dropped", 64'(hi), 64'd0);
      wait_done(3, lat);
      check("collide_latency", 64'(lat), 64'd34);
      check("collide_hi", 64'(hi), 64'd0);
      check("collide_lo", 64'(lo), 64'd63);

      // start pulse at iteration 5 is ignored
      @(negedge clk);
      start = 1'b1; op = MDU_OP_MULTU; a = 32'd7; b = 32'd9;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = (k == 5);
         if (k == 5) begin
            op = MDU_OP_DIVU; a = 32'd1000; b = 32'd3;
         end
         if (done) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
      check("ignore_start_latency", 64'(lat), 64'd34);
      check("ignore_start_hi", 64'(hi), 64'd0);
      check("ignore_start_lo", 64'(lo), 64'd63);

      // Reset at iteration 10 aborts immediately
      @(negedge clk);
      hi_we = 1'b1; wdata = 32'hAAAA_5555;
      @(negedge clk);
      hi_we = 1'b0;
      start = 1'b1; op = MDU_OP_MULTU; a = 32'd7; b = 32'd9;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("pre_reset_busy", 64'(busy), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      no_done = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) no_done = 1'b0;
      end
      check("abort_no_done", 64'(no_done), 64'd1);
      check("abort_hi_after", 64'(hi), 64'd0);
      check("abort_lo_after", 64'(lo), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
